// File: rtl/discrete_mac_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : discrete_mac_scheduler                                        |
// | Function : round-robin scheduler sharing one signed fixed-point          |
// |            multiplier between NUM_CH filter models, one frame per        |
// |            audio_clk_en, 2-stage product pipeline.                       |
// | Options  : DISCRETE_MAC_SAT_EN selects saturation instead of wrap.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module discrete_mac_scheduler #(
    parameter int NUM_CH = 4,
    parameter int A_W    = 17,
    parameter int COEF_W = 16,
    parameter int FRAC   = 12
) (
    input  logic                       clk,
    input  logic                       I_RSTn,
    input  logic                       audio_clk_en,
    input  logic [NUM_CH-1:0]          req,
    input  logic [NUM_CH*A_W-1:0]      op_a,
    input  logic [NUM_CH*COEF_W-1:0]   coef,
    output logic [NUM_CH-1:0]          gnt,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_CH)-1:0]  rsp_ch,
    output logic [A_W-1:0]             rsp_data,
    output logic                       frame_busy,
    output logic                       frame_done,
    output logic                       overrun,
    input  logic                       overrun_clr
);

    localparam int c_ch_w   = $clog2(NUM_CH);
    localparam int c_prod_w = A_W + COEF_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [c_ch_w-1:0]           ptr_q, ptr_d;
    logic                        overrun_q, overrun_d;

    logic                        s1_valid_q;
    logic [c_ch_w-1:0]           s1_ch_q;
    logic signed [c_prod_w-1:0]  s1_prod_q;
    logic                        rsp_valid_q;
    logic [c_ch_w-1:0]           rsp_ch_q;
    logic [A_W-1:0]              rsp_data_q;

    logic                        w_found;
    logic [c_ch_w-1:0]           w_sel;
    logic [c_ch_w:0]             w_sum;
    logic [c_ch_w-1:0]           w_idx;
    logic                        w_grant;
    logic signed [A_W-1:0]       w_op_a;
    logic signed [COEF_W-1:0]    w_coef;
    logic signed [c_prod_w-1:0]  w_prod;
    logic signed [c_prod_w-1:0]  w_shift;
    logic [A_W-1:0]              w_result;

    // First requester at or after the pointer, wrapping past NUM_CH-1.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_sum = {1'b0, ptr_q} + (c_ch_w+1)'(k);
            if (w_sum >= (c_ch_w+1)'(NUM_CH)) begin
                w_sum = w_sum - (c_ch_w+1)'(NUM_CH);
            end
            w_idx = w_sum[c_ch_w-1:0];
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt        = '0;
        frame_busy = 1'b0;
        frame_done = 1'b0;
        w_grant    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (audio_clk_en) state_d = S_ARB;
            end
            S_ARB: begin
                frame_busy = 1'b1;
                if (w_found) begin
                    gnt[w_sel] = 1'b1;
                    w_grant    = 1'b1;
                    ptr_d      = (w_sel == c_ch_w'(NUM_CH-1)) ? '0 : w_sel + 1'b1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                frame_busy = 1'b1;
                if (!s1_valid_q && !rsp_valid_q) state_d = S_DONE;
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_d    = audio_clk_en ? S_ARB : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // An enable arriving mid-frame is only recorded; set beats clear.
    always_comb begin
        overrun_d = overrun_q;
        if (overrun_clr) overrun_d = 1'b0;
        if (audio_clk_en && (state_q == S_ARB || state_q == S_DRAIN)) overrun_d = 1'b1;
    end

    assign w_op_a  = op_a[w_sel*A_W +: A_W];
    assign w_coef  = coef[w_sel*COEF_W +: COEF_W];
    assign w_prod  = c_prod_w'(w_op_a) * c_prod_w'(w_coef);
    assign w_shift = s1_prod_q >>> FRAC;

`ifdef DISCRETE_MAC_SAT_EN
    localparam logic signed [c_prod_w-1:0] c_sat_max = {{(COEF_W+1){1'b0}}, {(A_W-1){1'b1}}};
    localparam logic signed [c_prod_w-1:0] c_sat_min = {{(COEF_W+1){1'b1}}, {(A_W-1){1'b0}}};
    always_comb begin
        w_result = w_shift[A_W-1:0];
        if (w_shift > c_sat_max)      w_result = c_sat_max[A_W-1:0];
        else if (w_shift < c_sat_min) w_result = c_sat_min[A_W-1:0];
    end
`else
    logic w_unused_hi;
    assign w_unused_hi = ^w_shift[c_prod_w-1:A_W];
    assign w_result    = w_shift[A_W-1:0];
`endif

    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            overrun_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            s1_prod_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_ch_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            overrun_q   <= overrun_d;
            s1_valid_q  <= w_grant;
            rsp_valid_q <= s1_valid_q;
            if (w_grant) begin
                s1_ch_q   <= w_sel;
                s1_prod_q <= w_prod;
            end
            if (s1_valid_q) begin
                rsp_ch_q   <= s1_ch_q;
                rsp_data_q <= w_result;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_ch    = rsp_ch_q;
    assign rsp_data  = rsp_data_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_discrete_mac_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_discrete_mac_scheduler                                     |
// | Function : directed bench with response scoreboard for the MAC scheduler |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_discrete_mac_scheduler;

    localparam int NUM_CH = 4;
    localparam int A_W    = 17;
    localparam int COEF_W = 16;
    localparam int FRAC   = 12;

    logic                      clk = 1'b0;
    logic                      I_RSTn;
    logic                      audio_clk_en;
    logic [NUM_CH-1:0]         req;
    logic [NUM_CH*A_W-1:0]     op_a;
    logic [NUM_CH*COEF_W-1:0]  coef;
    logic [NUM_CH-1:0]         gnt;
    logic                      rsp_valid;
    logic [1:0]                rsp_ch;
    logic [A_W-1:0]            rsp_data;
    logic                      frame_busy;
    logic                      frame_done;
    logic                      overrun;
    logic                      overrun_clr;

    discrete_mac_scheduler #(
        .NUM_CH (NUM_CH),
        .A_W    (A_W),
        .COEF_W (COEF_W),
        .FRAC   (FRAC)
    ) dut (
        .clk          (clk),
        .I_RSTn       (I_RSTn),
        .audio_clk_en (audio_clk_en),
        .req          (req),
        .op_a         (op_a),
        .coef         (coef),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_ch       (rsp_ch),
        .rsp_data     (rsp_data),
        .frame_busy   (frame_busy),
        .frame_done   (frame_done),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             ch;
        logic [A_W-1:0] data;
        int             due;
    } exp_t;

    exp_t           sbq[$];
    logic [A_W-1:0] last_data = '0;
    int             av[NUM_CH];
    int             cv[NUM_CH];
    int             checks = 0;
    int             errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [A_W-1:0] model(input int a, input int c);
        longint full;
        longint sh;
        full = longint'(a) * longint'(c);
        sh   = full >>> FRAC;
`ifdef DISCRETE_MAC_SAT_EN
        if (sh > (longint'(1) <<< (A_W-1)) - 1) sh = (longint'(1) <<< (A_W-1)) - 1;
        else if (sh < -(longint'(1) <<< (A_W-1))) sh = -(longint'(1) <<< (A_W-1));
`endif
        return sh[A_W-1:0];
    endfunction

    task automatic set_op(input int ch, input int a, input int c);
        op_a[ch*A_W +: A_W]    = a[A_W-1:0];
        coef[ch*COEF_W +: COEF_W] = c[COEF_W-1:0];
        av[ch] = a;
        cv[ch] = c;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic expect_gnt(input int ch);
        logic [NUM_CH-1:0] e;
        exp_t x;
        e = (ch < 0) ? '0 : NUM_CH'(1) << ch;
        chk("gnt", 64'(gnt), 64'(e));
        if (ch >= 0) begin
            x.ch   = ch;
            x.data = model(av[ch], cv[ch]);
            x.due  = cyc + 2;
            sbq.push_back(x);
        end
    endtask

    // Enable cycle with the given requests visible; leaves the bench in the first ARB cycle.
    task automatic start_frame(input logic [NUM_CH-1:0] mask);
        next();
        audio_clk_en = 1'b1;
        req = mask;
        at_neg();
        chk("gnt_in_enable_cycle", 64'(gnt), 64'(0));
        next();
        audio_clk_en = 1'b0;
    endtask

    task automatic wait_done();
        int seen;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            next();
            at_neg();
            if (frame_done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk("frame_done_seen", 64'(seen), 64'(1));
        chk("sb_empty_at_done", 64'(sbq.size()), 64'(0));
        next();
        at_neg();
        chk("frame_done_one_cycle", 64'(frame_done), 64'(0));
        chk("idle_not_busy", 64'(frame_busy), 64'(0));
    endtask

    task automatic end_frame();
        next();
        req = '0;
        at_neg();
        expect_gnt(-1);
        wait_done();
    endtask

    // Response side of the scoreboard.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rsp_ch", 64'(rsp_ch), 64'(e.ch));
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
                chk("rsp_latency", 64'(cyc), 64'(e.due));
                last_data = e.data;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d required finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        I_RSTn = 1'b0;
        audio_clk_en = 1'b0;
        overrun_clr = 1'b0;
        req = '0;
        op_a = '0;
        coef = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            av[i] = 0;
            cv[i] = 0;
        end
        at_neg();
        at_neg();
        chk("rst_gnt", 64'(gnt), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_ch", 64'(rsp_ch), 64'(0));
        chk("rst_rsp_data", 64'(rsp_data), 64'(0));
        chk("rst_busy", 64'(frame_busy), 64'(0));
        chk("rst_done", 64'(frame_done), 64'(0));
        chk("rst_overrun", 64'(overrun), 64'(0));
        next();
        I_RSTn = 1'b1;

        // Single request: 4096 * 2048 >> 12 = 2048.
        set_op(0, 4096, 2048);
        start_frame(4'b0001);
        at_neg();
        expect_gnt(0);
        chk("busy_in_arb", 64'(frame_busy), 64'(1));
        end_frame();

        // Pointer is now 1; a lone ch3 request brings it back to 0.
        set_op(3, 100, -300);
        start_frame(4'b1000);
        at_neg();
        expect_gnt(3);
        end_frame();

        // Round-robin with all four held; operands refreshed after each grant.
        set_op(0, 1000, 4096);
        set_op(1, -3, 4097);
        set_op(2, 40000, -20000);
        set_op(3, 12345, 7);
        start_frame(4'b1111);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                next();
                set_op((i - 1) % NUM_CH, 5000 - 1234 * i, -2000 + 999 * i);
            end
            at_neg();
            expect_gnt(i % NUM_CH);
        end
        end_frame();

        // ch2 moves the pointer to 3, ch1 wraps, ch0 hits the overflow boundary.
        set_op(2, 7, 9);
        start_frame(4'b0100);
        at_neg();
        expect_gnt(2);
        next();
        set_op(1, -4096, 4091);
        req = 4'b0010;
        at_neg();
        expect_gnt(1);
        next();
        set_op(0, 65535, 32767);
        req = 4'b0001;
        at_neg();
        expect_gnt(0);
        end_frame();
        chk("rsp_data_hold", 64'(rsp_data), 64'(last_data));
        chk("rsp_valid_low", 64'(rsp_valid), 64'(0));

        // Overrun during ARB, then clear and enable together during DRAIN.
        chk("overrun_pre", 64'(overrun), 64'(0));
        set_op(0, 300, 4096);
        set_op(1, -500, 8192);
        start_frame(4'b0011);
        at_neg();
        expect_gnt(1);
        next();
        audio_clk_en = 1'b1;
        at_neg();
        expect_gnt(0);
        next();
        audio_clk_en = 1'b0;
        at_neg();
        chk("overrun_set", 64'(overrun), 64'(1));
        expect_gnt(1);
        next();
        req = '0;
        at_neg();
        expect_gnt(-1);
        next();
        overrun_clr = 1'b1;
        audio_clk_en = 1'b1;
        at_neg();
        chk("busy_in_drain", 64'(frame_busy), 64'(1));
        next();
        overrun_clr = 1'b0;
        audio_clk_en = 1'b0;
        at_neg();
        chk("overrun_set_wins", 64'(overrun), 64'(1));
        wait_done();
        next();
        overrun_clr = 1'b1;
        next();
        overrun_clr = 1'b0;
        at_neg();
        chk("overrun_cleared", 64'(overrun), 64'(0));

        // Reset one cycle after a grant: that product must never appear.
        set_op(2, 1111, 2222);
        start_frame(4'b0100);
        at_neg();
        chk("gnt_before_reset", 64'(gnt), 64'(4'b0100));
        next();
        req = '0;
        I_RSTn = 1'b0;
        at_neg();
        chk("mid_rst_gnt", 64'(gnt), 64'(0));
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mid_rst_rsp_ch", 64'(rsp_ch), 64'(0));
        chk("mid_rst_rsp_data", 64'(rsp_data), 64'(0));
        chk("mid_rst_busy", 64'(frame_busy), 64'(0));
        chk("mid_rst_done", 64'(frame_done), 64'(0));
        chk("mid_rst_overrun", 64'(overrun), 64'(0));
        next();
        next();
        I_RSTn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next();
            at_neg();
            chk("post_rst_idle", 64'(frame_busy), 64'(0));
        end

        // Pointer restarted at 0, so ch1 wins over ch3.
        set_op(1, -8191, 3);
        set_op(3, 2, 2);
        start_frame(4'b1010);
        at_neg();
        expect_gnt(1);
        end_frame();

        chk("sb_empty_end", 64'(sbq.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
